// File: rtl/store_buffer_unit_if.sv
// Data-memory write channel of the store buffer: valid/ready handshake carrying
// one word-aligned store (address, replicated data, byte strobe) per transfer.
interface store_buffer_unit_if;
    logic        dmem_wr_valid;
    logic        dmem_wr_ready;
    logic [31:0] dmem_wr_addr;
    logic [31:0] dmem_wr_data;
    logic [3:0]  dmem_wr_strb;

    modport master (
        output dmem_wr_valid,
        output dmem_wr_addr,
        output dmem_wr_data,
        output dmem_wr_strb,
        input  dmem_wr_ready
    );

    modport slave (
        input  dmem_wr_valid,
        input  dmem_wr_addr,
        input  dmem_wr_data,
        input  dmem_wr_strb,
        output dmem_wr_ready
    );
endinterface

// File: rtl/store_buffer_unit.sv
// MEM-stage store buffer: formats SB/SH/SW into aligned word writes, queues them
// in a small in-order FIFO, drains to data memory and reports load-after-store hazards.
module store_buffer_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_write,
    input  logic [2:0]                store_type,
    input  logic [31:0]               store_addr,
    input  logic [31:0]               store_data,
    output logic                      store_stall,
    output logic                      store_fault,
    input  logic                      ld_check,
    input  logic [31:0]               ld_addr,
    output logic                      ld_hazard,
    store_buffer_unit_if.master       dmem,
    output logic                      sb_empty
);

    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [2:0]  ST_SB  = 3'b000;
    localparam logic [2:0]  ST_SH  = 3'b001;
    localparam logic [2:0]  ST_SW  = 3'b010;

    typedef struct packed {
        logic [29:0] word;
        logic [31:0] data;
        logic [3:0]  strb;
    } sb_entry_t;

    sb_entry_t              entries [DEPTH];
    logic [DEPTH-1:0]       entry_valid;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic [3:0]             fmt_strb;
    logic [31:0]            fmt_data;
    logic                   illegal;
    logic                   misaligned;
    logic                   full;
    logic                   enq;
    logic                   deq;
    sb_entry_t              new_entry;
    sb_entry_t              head;

    // Byte-lane formatting of the incoming store.
    always_comb begin
        fmt_strb   = 4'b0000;
        fmt_data   = 32'h0;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (store_type)
            ST_SB: begin
                fmt_strb = 4'b0001 << store_addr[1:0];
                fmt_data = {4{store_data[7:0]}};
            end
            ST_SH: begin
                fmt_strb   = 4'b0011 << store_addr[1:0];
                fmt_data   = {2{store_data[15:0]}};
                misaligned = store_addr[0];
            end
            ST_SW: begin
                fmt_strb   = 4'b1111;
                fmt_data   = store_data;
                misaligned = (store_addr[1:0] != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

    // Full is judged on registered count only, so a dequeue cannot release a stall in the same cycle.
    always_comb begin
        full        = (count == CNT_W'(DEPTH));
        store_fault = mem_write & (illegal | misaligned);
        store_stall = mem_write & ~store_fault & full;
        enq         = mem_write & ~store_fault & ~full;
        deq         = (count != '0) & dmem.dmem_wr_ready;
        new_entry   = '{word: store_addr[31:2], data: fmt_data, strb: fmt_strb};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (enq) begin
                entries[wr_ptr]     <= new_entry;
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry is presented directly from storage, so it holds steady under backpressure.
    always_comb begin
        head               = entries[rd_ptr];
        dmem.dmem_wr_valid = (count != '0);
        dmem.dmem_wr_addr  = {head.word, 2'b00};
        dmem.dmem_wr_data  = head.data;
        dmem.dmem_wr_strb  = head.strb;
        sb_empty           = (count == '0);
    end

    // Word-granular match against buffered stores only; same-cycle enqueue is not visible here.
    always_comb begin
        ld_hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] &&
                ((({entries[i].word, 2'b00} ^ ld_addr) & 32'hFFFF_FFFC) == 32'h0)) begin
                ld_hazard = 1'b1;
            end
        end
        ld_hazard = ld_hazard & ld_check;
    end

endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed self-checking bench for store_buffer_unit: formatting, faults,
// backpressure, hazards, handshake stability and asynchronous reset.
module tb_store_buffer_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_write;
    logic [2:0]  store_type;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic        store_stall;
    logic        store_fault;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        sb_empty;

    int checks;
    int failures;

    store_buffer_unit_if dmem_if ();

    store_buffer_unit #(.DEPTH(2), .PTR_W(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_write   (mem_write),
        .store_type  (store_type),
        .store_addr  (store_addr),
        .store_data  (store_data),
        .store_stall (store_stall),
        .store_fault (store_fault),
        .ld_check    (ld_check),
        .ld_addr     (ld_addr),
        .ld_hazard   (ld_hazard),
        .dmem        (dmem_if.master),
        .sb_empty    (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        mem_write  = 1'b1;
        store_type = t;
        store_addr = a;
        store_data = d;
        #1;
    endtask

    task automatic idle_store();
        mem_write = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({dmem_if.dmem_wr_valid, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data, dmem_if.dmem_wr_strb, sb_empty}
            !== {1'b0, 32'h0, 32'h0, 4'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state got v=%0b a=%h d=%h s=%b e=%0b want v=0 a=0 d=0 s=0 e=1",
                     dmem_if.dmem_wr_valid, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data,
                     dmem_if.dmem_wr_strb, sb_empty);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({store_stall, store_fault, ld_hazard} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle_flags got %b want 000", {store_stall, store_fault, ld_hazard});
        end
    endtask

    task automatic test_format();
        dmem_if.dmem_wr_ready = 1'b1;
        drive_store(3'b000, 32'h0000_0103, 32'hAABB_CCDD);
        checks++;
        if ({store_fault, store_stall} !== 2'b00) begin
            failures++;
            $display("FAIL sb_accept got fault/stall=%b want 00", {store_fault, store_stall});
        end
        step();
        idle_store();
        checks++;
        if ({dmem_if.dmem_wr_valid, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data, dmem_if.dmem_wr_strb, sb_empty}
            !== {1'b1, 32'h0000_0100, 32'hDDDD_DDDD, 4'b1000, 1'b0}) begin
            failures++;
            $display("FAIL sb_format got v=%0b a=%h d=%h s=%b e=%0b want v=1 a=00000100 d=dddddddd s=1000 e=0",
                     dmem_if.dmem_wr_valid, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data,
                     dmem_if.dmem_wr_strb, sb_empty);
        end
        step();
        checks++;
        if ({dmem_if.dmem_wr_valid, sb_empty} !== 2'b01) begin
            failures++;
            $display("FAIL sb_drained got v/e=%b want 01", {dmem_if.dmem_wr_valid, sb_empty});
        end
        // Aligned upper halfword.
        dmem_if.dmem_wr_ready = 1'b0;
        drive_store(3'b001, 32'h0000_0102, 32'h1234_5678);
        step();
        idle_store();
        checks++;
        if ({dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data, dmem_if.dmem_wr_strb}
            !== {32'h0000_0100, 32'h5678_5678, 4'b1100}) begin
            failures++;
            $display("FAIL sh_format got a=%h d=%h s=%b want a=00000100 d=56785678 s=1100",
                     dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data, dmem_if.dmem_wr_strb);
        end
        dmem_if.dmem_wr_ready = 1'b1;
        step();
        drive_store(3'b010, 32'h0000_0008, 32'hCAFE_F00D);
        step();
        idle_store();
        checks++;
        if ({dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data, dmem_if.dmem_wr_strb}
            !== {32'h0000_0008, 32'hCAFE_F00D, 4'b1111}) begin
            failures++;
            $display("FAIL sw_format got a=%h d=%h s=%b want a=00000008 d=cafef00d s=1111",
                     dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data, dmem_if.dmem_wr_strb);
        end
        step();
    endtask

    task automatic test_fault();
        dmem_if.dmem_wr_ready = 1'b1;
        drive_store(3'b001, 32'h0000_0201, 32'h1111_2222);
        checks++;
        if ({store_fault, store_stall} !== 2'b10) begin
            failures++;
            $display("FAIL sh_misaligned got fault/stall=%b want 10", {store_fault, store_stall});
        end
        step();
        drive_store(3'b011, 32'h0000_0200, 32'h1111_2222);
        checks++;
        if ({store_fault, sb_empty, dmem_if.dmem_wr_valid} !== 3'b110) begin
            failures++;
            $display("FAIL illegal_type got fault/empty/valid=%b want 110",
                     {store_fault, sb_empty, dmem_if.dmem_wr_valid});
        end
        step();
        drive_store(3'b010, 32'h0000_0202, 32'h1111_2222);
        checks++;
        if (store_fault !== 1'b1) begin
            failures++;
            $display("FAIL sw_misaligned got fault=%0b want 1", store_fault);
        end
        step();
        idle_store();
        checks++;
        if ({sb_empty, dmem_if.dmem_wr_valid, store_fault} !== 3'b100) begin
            failures++;
            $display("FAIL fault_no_enqueue got empty/valid/fault=%b want 100",
                     {sb_empty, dmem_if.dmem_wr_valid, store_fault});
        end
    endtask

    task automatic test_back_to_back();
        dmem_if.dmem_wr_ready = 1'b0;
        drive_store(3'b010, 32'h0000_0010, 32'h0000_00A1);
        step();
        drive_store(3'b010, 32'h0000_0014, 32'h0000_00A2);
        checks++;
        if (store_stall !== 1'b0) begin
            failures++;
            $display("FAIL second_no_stall got stall=%0b want 0", store_stall);
        end
        step();
        // Misaligned store while full faults instead of stalling.
        drive_store(3'b010, 32'h0000_001A, 32'h0000_00A3);
        checks++;
        if ({store_fault, store_stall} !== 2'b10) begin
            failures++;
            $display("FAIL fault_while_full got fault/stall=%b want 10", {store_fault, store_stall});
        end
        drive_store(3'b010, 32'h0000_0018, 32'h0000_00A3);
        checks++;
        if (store_stall !== 1'b1) begin
            failures++;
            $display("FAIL third_stall got stall=%0b want 1", store_stall);
        end
        dmem_if.dmem_wr_ready = 1'b1;
        #1;
        checks++;
        if ({store_stall, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data} !== {1'b1, 32'h0000_0010, 32'h0000_00A1}) begin
            failures++;
            $display("FAIL no_bypass got stall=%0b a=%h d=%h want stall=1 a=00000010 d=000000a1",
                     store_stall, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data);
        end
        step();
        dmem_if.dmem_wr_ready = 1'b0;
        #1;
        checks++;
        if ({store_stall, dmem_if.dmem_wr_addr} !== {1'b0, 32'h0000_0014}) begin
            failures++;
            $display("FAIL third_released got stall=%0b a=%h want stall=0 a=00000014",
                     store_stall, dmem_if.dmem_wr_addr);
        end
        step();
        idle_store();
        dmem_if.dmem_wr_ready = 1'b1;
        #1;
        checks++;
        if ({dmem_if.dmem_wr_valid, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data} !== {1'b1, 32'h0000_0014, 32'h0000_00A2}) begin
            failures++;
            $display("FAIL order_second got v=%0b a=%h d=%h want v=1 a=00000014 d=000000a2",
                     dmem_if.dmem_wr_valid, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data);
        end
        step();
        checks++;
        if ({dmem_if.dmem_wr_valid, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data} !== {1'b1, 32'h0000_0018, 32'h0000_00A3}) begin
            failures++;
            $display("FAIL order_third got v=%0b a=%h d=%h want v=1 a=00000018 d=000000a3",
                     dmem_if.dmem_wr_valid, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data);
        end
        step();
        checks++;
        if ({dmem_if.dmem_wr_valid, sb_empty} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_drained got v/e=%b want 01", {dmem_if.dmem_wr_valid, sb_empty});
        end
    endtask

    task automatic test_hazard();
        dmem_if.dmem_wr_ready = 1'b0;
        drive_store(3'b010, 32'h0000_0040, 32'h0000_0040);
        step();
        ld_check = 1'b1;
        ld_addr  = 32'h0000_0042;
        drive_store(3'b010, 32'h0000_0044, 32'h0000_0044);
        checks++;
        if (ld_hazard !== 1'b1) begin
            failures++;
            $display("FAIL hazard_same_word got %0b want 1", ld_hazard);
        end
        ld_addr = 32'h0000_0044;
        #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            failures++;
            $display("FAIL hazard_enqueue_not_seen got %0b want 0", ld_hazard);
        end
        step();
        idle_store();
        checks++;
        if (ld_hazard !== 1'b1) begin
            failures++;
            $display("FAIL hazard_second_entry got %0b want 1", ld_hazard);
        end
        ld_addr = 32'h0000_0048;
        #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            failures++;
            $display("FAIL hazard_other_word got %0b want 0", ld_hazard);
        end
        ld_check = 1'b0;
        ld_addr  = 32'h0000_0040;
        #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            failures++;
            $display("FAIL hazard_no_check got %0b want 0", ld_hazard);
        end
        ld_check = 1'b1;
        dmem_if.dmem_wr_ready = 1'b1;
        #1;
        checks++;
        if (ld_hazard !== 1'b1) begin
            failures++;
            $display("FAIL hazard_head_dequeue got %0b want 1", ld_hazard);
        end
        step();
        checks++;
        if (ld_hazard !== 1'b0) begin
            failures++;
            $display("FAIL hazard_after_pop got %0b want 0", ld_hazard);
        end
        ld_check = 1'b0;
        step();
    endtask

    task automatic test_hold_and_simul();
        dmem_if.dmem_wr_ready = 1'b0;
        drive_store(3'b001, 32'h0000_0062, 32'h0000_BEEF);
        step();
        idle_store();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({dmem_if.dmem_wr_valid, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data, dmem_if.dmem_wr_strb}
                !== {1'b1, 32'h0000_0060, 32'hBEEF_BEEF, 4'b1100}) begin
                failures++;
                $display("FAIL hold_stable cycle=%0d got v=%0b a=%h d=%h s=%b want v=1 a=00000060 d=beefbeef s=1100",
                         c, dmem_if.dmem_wr_valid, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data,
                         dmem_if.dmem_wr_strb);
            end
            step();
        end
        dmem_if.dmem_wr_ready = 1'b1;
        drive_store(3'b000, 32'h0000_0071, 32'h0000_005A);
        step();
        idle_store();
        dmem_if.dmem_wr_ready = 1'b0;
        #1;
        checks++;
        if ({dmem_if.dmem_wr_valid, sb_empty, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data, dmem_if.dmem_wr_strb}
            !== {1'b1, 1'b0, 32'h0000_0070, 32'h5A5A_5A5A, 4'b0010}) begin
            failures++;
            $display("FAIL simul_enq_deq got v=%0b e=%0b a=%h d=%h s=%b want v=1 e=0 a=00000070 d=5a5a5a5a s=0010",
                     dmem_if.dmem_wr_valid, sb_empty, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data,
                     dmem_if.dmem_wr_strb);
        end
        dmem_if.dmem_wr_ready = 1'b1;
        step();
        checks++;
        if ({dmem_if.dmem_wr_valid, sb_empty} !== 2'b01) begin
            failures++;
            $display("FAIL simul_count_one got v/e=%b want 01", {dmem_if.dmem_wr_valid, sb_empty});
        end
    endtask

    task automatic test_reset_mid_drain();
        dmem_if.dmem_wr_ready = 1'b0;
        drive_store(3'b010, 32'h0000_0080, 32'h0000_0001);
        step();
        drive_store(3'b010, 32'h0000_0084, 32'h0000_0002);
        step();
        drive_store(3'b010, 32'h0000_0088, 32'h0000_0003);
        checks++;
        if (store_stall !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_full got stall=%0b want 1", store_stall);
        end
        idle_store();
        dmem_if.dmem_wr_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_if.dmem_wr_valid, sb_empty, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data, dmem_if.dmem_wr_strb}
            !== {1'b0, 1'b1, 32'h0, 32'h0, 4'h0}) begin
            failures++;
            $display("FAIL async_reset got v=%0b e=%0b a=%h d=%h s=%b want v=0 e=1 a=0 d=0 s=0",
                     dmem_if.dmem_wr_valid, sb_empty, dmem_if.dmem_wr_addr, dmem_if.dmem_wr_data,
                     dmem_if.dmem_wr_strb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({dmem_if.dmem_wr_valid, sb_empty} !== 2'b01) begin
            failures++;
            $display("FAIL reset_discard got v/e=%b want 01", {dmem_if.dmem_wr_valid, sb_empty});
        end
    endtask

    initial begin
        checks                = 0;
        failures              = 0;
        rst_n                 = 1'b0;
        mem_write             = 1'b0;
        store_type            = 3'b000;
        store_addr            = 32'h0;
        store_data            = 32'h0;
        ld_check              = 1'b0;
        ld_addr               = 32'h0;
        dmem_if.dmem_wr_ready = 1'b0;

        test_reset();
        test_format();
        test_fault();
        test_back_to_back();
        test_hazard();
        test_hold_and_simul();
        test_reset_mid_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
